uart_frame_checker: RTL



---
 rtl/uart_frame_checker.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_checker.sv
// UART line checker: samples LINE_IN, compares each frame with a queue of expected words.
// Optional define UART_FRAME_CHECKER_COUNTERS_EN enables FRAME_COUNT / ERR_COUNT.
module uart_frame_checker #(
    parameter int DATA_WIDTH     = 8,
    parameter int EXP_DEPTH      = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      LINE_IN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [DATA_WIDTH-1:0]     EXP_DATA,
    input  logic                      EXP_VALID,
    output logic                      EXP_READY,
    output logic                      FRAME_DONE,
    output logic                      MATCH,
    output logic                      MISMATCH,
    output logic                      PAR_ERR,
    output logic                      STP_ERR,
    output logic                      NO_EXP,
    output logic                      GLITCH,
    output logic [DATA_WIDTH-1:0]     RX_DATA,
    output logic [CNT_WIDTH-1:0]      FRAME_COUNT,
    output logic [CNT_WIDTH-1:0]      ERR_COUNT
);

    localparam int AW = $clog2(EXP_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (DATA_WIDTH > 8) ? 4 : 3;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_REPORT
    } state_t;

    state_t                    state_q, state_d;
    logic                      line_q;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0]     rx_q, rx_d;
    logic                      par_err_q, par_err_d;
    logic                      stp_err_q, stp_err_d;
    logic [PRESCALE_WIDTH-1:0] pre_clamp;
    logic                      done;
    logic                      glitch;

    logic [DATA_WIDTH-1:0]     mem_q [EXP_DEPTH];
    logic [AW-1:0]             wr_q, wr_d;
    logic [AW-1:0]             rd_q, rd_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      push, pop, empty, data_eq;

    assign pre_clamp = (PRESCALE < PRESCALE_WIDTH'(4)) ? PRESCALE_WIDTH'(4) : PRESCALE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pre_d     = pre_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        done      = 1'b0;
        glitch    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!line_q) begin
                    state_d   = S_START;
                    cnt_d     = PRESCALE_WIDTH'(1);
                    pre_d     = pre_clamp;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    bit_d     = '0;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            S_START: begin
                // cnt counts cycles since line_q first showed the falling edge
                if (cnt_q == (pre_q >> 1)) begin
                    cnt_d = PRESCALE_WIDTH'(1);
                    if (line_q) begin
                        glitch  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == pre_q) begin
                    cnt_d   = PRESCALE_WIDTH'(1);
                    shift_d = {line_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_q == BW'(DATA_WIDTH - 1)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt_q == pre_q) begin
                    cnt_d     = PRESCALE_WIDTH'(1);
                    par_err_d = line_q != ((^shift_q) ^ par_typ_q);
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == pre_q) begin
                    stp_err_d = ~line_q;
                    rx_d      = shift_q;
                    state_d   = S_REPORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REPORT: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            line_q    <= 1'b1;
            cnt_q     <= '0;
            pre_q     <= PRESCALE_WIDTH'(4);
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_q      <= '0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= LINE_IN;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_q      <= rx_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
        end
    end

    // Queue: occupancy uses count_q, so a push in REPORT cannot satisfy that frame
    assign empty     = (count_q == '0);
    assign EXP_READY = (count_q != CW'(EXP_DEPTH));
    assign push      = EXP_VALID & EXP_READY;
    assign pop       = done & ~empty;
    assign data_eq   = (mem_q[rd_q] == rx_q);

    always_comb begin
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_q] <= EXP_DATA;
        end
    end

    assign FRAME_DONE = done;
    assign GLITCH     = glitch;
    assign RX_DATA    = rx_q;
    assign PAR_ERR    = done & par_err_q;
    assign STP_ERR    = done & stp_err_q;
    assign NO_EXP     = done & empty;
    assign MISMATCH   = done & ~empty & ~data_eq;
    assign MATCH      = done & ~empty & data_eq & ~par_err_q & ~stp_err_q;

`ifdef UART_FRAME_CHECKER_COUNTERS_EN
    logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [CNT_WIDTH-1:0] ecnt_q, ecnt_d;
    logic                 err;

    assign err = MISMATCH | PAR_ERR | STP_ERR | NO_EXP;

    always_comb begin
        fcnt_d = fcnt_q;
        ecnt_d = ecnt_q;
        if (done && !(&fcnt_q)) fcnt_d = fcnt_q + 1'b1;
        if (err && !(&ecnt_q)) ecnt_d = ecnt_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fcnt_q <= '0;
            ecnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign FRAME_COUNT = fcnt_q;
    assign ERR_COUNT   = ecnt_q;
`else
    assign FRAME_COUNT = '0;
    assign ERR_COUNT   = '0;
`endif

endmodule
